// File: rtl/timer_pkg.sv
// Shared timer definitions: FSM state encoding, TCR field positions,
// register reset values and the prescaler divide limit.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } timer_state_e;

  localparam int TCR_TIMER_EN = 0;
  localparam int TCR_DIV_EN   = 1;
  localparam int TCR_DIV_LSB  = 8;
  localparam int TCR_DIV_MSB  = 11;

  // Only timer_en, div_en and div_val are implemented; everything else reads 0.
  localparam logic [31:0] TCR_MASK = 32'h0000_0F03;
  localparam logic [31:0] TCR_RST  = 32'h0000_0100;
  localparam logic [63:0] TCMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [3:0]  DIV_MAX  = 4'd8;

  // Terminal count of the divider for a 2^n period.
  function automatic logic [7:0] div_mask(input logic [3:0] n);
    logic [8:0] full;
    full = (9'd1 << n) - 9'd1;
    return full[7:0];
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divider counter and tick generation: tick is high every cycle in bypass,
// otherwise once per 2^div_val counting cycles.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       run,
  input  logic       div_en,
  input  logic [3:0] div_val,
  output logic       tick
);

  logic [7:0] div_cnt;
  logic [7:0] mask;
  logic       tick_q;
  logic       bypass;

  assign mask   = div_mask(div_val);
  assign bypass = !div_en || (div_val == 4'd0);

  // The tick is registered so a full 2^N cycles elapse after a clear before
  // the first pulse; both counter and tick freeze whenever run is low.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_cnt <= 8'd0;
      tick_q  <= 1'b0;
    end else if (run) begin
      div_cnt <= (div_cnt == mask) ? 8'd0 : div_cnt + 8'd1;
      tick_q  <= (div_cnt == mask);
    end
  end

  assign tick = bypass || tick_q;

endmodule

// File: rtl/timer_ctrl.sv
// Timer control: TCR/TIER/TISR/TCMP registers, run FSM, compare interrupt.
// Define TIMER_HALT_EN to add the debug-halt state and its dbg_mode/halt_req inputs.
module timer_ctrl
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tcr_wr_sel,
  input  logic        tier_wr_sel,
  input  logic        tisr_wr_sel,
  input  logic        tcmp0_wr_sel,
  input  logic        tcmp1_wr_sel,
  input  logic [31:0] wdata,
  input  logic        cnt_clr_req,
  input  logic [63:0] cnt,
`ifdef TIMER_HALT_EN
  input  logic        dbg_mode,
  input  logic        halt_req,
`endif
  output logic        cnt_en,
  output logic        count_clr,
  output logic [31:0] tcr_q,
  output logic [63:0] tcmp_q,
  output logic        tier_q,
  output logic        tisr_q,
  output logic        tim_int
);

  timer_state_e state, state_nxt;
  logic       timer_en;
  logic       div_en;
  logic [3:0] div_val;
  logic       tcr_acc;
  logic       halt_hold;
  logic       run_entry;
  logic       presc_clr;
  logic       tick;
  logic       tisr_set;

  assign timer_en = tcr_q[TCR_TIMER_EN];
  assign div_en   = tcr_q[TCR_DIV_EN];
  assign div_val  = tcr_q[TCR_DIV_MSB:TCR_DIV_LSB];
  assign tcr_acc  = tcr_wr_sel && (wdata[TCR_DIV_MSB:TCR_DIV_LSB] <= DIV_MAX);

`ifdef TIMER_HALT_EN
  assign halt_hold = dbg_mode && halt_req;
`else
  assign halt_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (timer_en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!timer_en)     state_nxt = ST_IDLE;
        else if (halt_hold) state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (!timer_en)       state_nxt = ST_IDLE;
        else if (!halt_hold) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Gating on timer_en drops cnt_en as soon as the disabling write lands,
  // one cycle ahead of the state change.
  always_comb begin
    cnt_en = (state == ST_RUN) && timer_en && tick && !count_clr;
  end

  // Only a fresh start clears the divider; returning from HALT keeps its phase.
  assign run_entry = (state == ST_IDLE) && (state_nxt == ST_RUN);
  assign presc_clr = run_entry || tcr_acc || cnt_clr_req;

  timer_prescaler u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clr     (presc_clr),
    .run     (state == ST_RUN),
    .div_en  (div_en),
    .div_val (div_val),
    .tick    (tick)
  );

  // While running, only the enable bit may change so the divide setting stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcr_q <= TCR_RST;
    end else if (tcr_acc) begin
      if (timer_en) tcr_q[TCR_TIMER_EN] <= wdata[TCR_TIMER_EN];
      else          tcr_q <= wdata & TCR_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_clr <= 1'b0;
      tcmp_q    <= TCMP_RST;
      tier_q    <= 1'b0;
    end else begin
      count_clr <= cnt_clr_req;
      if (tcmp0_wr_sel) tcmp_q[31:0]  <= wdata;
      if (tcmp1_wr_sel) tcmp_q[63:32] <= wdata;
      if (tier_wr_sel)  tier_q        <= wdata[0];
    end
  end

  // A match in the same cycle as a W1C wins, so no event is lost.
  assign tisr_set = (cnt == tcmp_q);

  always_ff @(posedge clk) begin
    if (rst) tisr_q <= 1'b0;
    else     tisr_q <= tisr_set || (tisr_q && !(tisr_wr_sel && wdata[0]));
  end

  assign tim_int = tisr_q && tier_q;

endmodule
